regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
Round-robin arbiter that shares the single write port and single read port of the RegisterFile between R requesters.
- Grants at most one transaction (read or write) per clock.
- Drives the RegisterFile address, data and enable pins directly.
- Returns read data through a registered response with fixed 1-cycle latency.
- Sits between bus-side clients and RegisterFile #(N, M).

Parameters:
R, 2, number of requesters (R >= 2, not required to be a power of two)
N, 8, register data width; must match RegisterFile N
M, 4, number of registers; must match RegisterFile M (power of two, >= 2)
AW, $clog2(M), address width (localparam, derived)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  R  request pending, one bit per requester
req_we  input  R  1 = write, 0 = read, per requester
req_addr  input  R*AW  register address; requester i occupies bits [i*AW +: AW]
req_wdata  input  R*N  write data; requester i occupies bits [i*N +: N]
req_ready  output  R  one-hot grant; a request is accepted when valid & ready
rsp_valid  output  R  one-cycle pulse: read data for requester i is valid
rsp_rdata  output  N  registered read data, shared by all requesters
rf_write_enable  output  1  to RegisterFile write_enable
rf_write_addr  output  AW  to RegisterFile write_addr
rf_write_data  output  N  to RegisterFile write_data
rf_read_addr  output  AW  to RegisterFile read_addr
rf_read_data  input  N  from RegisterFile read_data (combinational)

Behaviour:
- Reset (async, active-high):
  - rr_ptr = 0, rsp_valid = 0, rsp_rdata = 0.
  - Combinational outputs are forced inactive while reset = 1: req_ready = 0, rf_write_enable = 0.
- Arbitration (combinational):
  - Winner = first i with req_valid[i] = 1, scanning rr_ptr, rr_ptr+1, ..., wrapping mod R.
  - req_ready = one-hot(winner) if any req_valid is set, else 0.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer: on an accepted transaction, rr_ptr <= (winner + 1) mod R. No grant leaves rr_ptr unchanged. The wrap at R-1 goes to 0 for non-power-of-two R.
- Write grant:
  - rf_write_enable = 1, rf_write_addr = addr[winner], rf_write_data = wdata[winner], all in the grant cycle.
  - The register updates at that edge.
  - No response is generated for writes.
- Read grant:
  - rf_read_addr = addr[winner] in the grant cycle.
  - At the edge: rsp_rdata <= rf_read_data and rsp_valid <= one-hot(winner).
  - The pulse lasts exactly 1 cycle; there is no response backpressure.
- Idle outputs:
  - rf_read_addr holds the last granted read address when idle; rsp_rdata holds its last value.
  - rf_write_addr/rf_write_data = 0 when there is no write grant.
- Ordering:
  - A read granted the cycle after a write to the same address returns the new value.
  - Read and write are never granted in the same cycle.
- Holding requests: a requester holding req_valid with changing addr/data is sampled only in its grant cycle.
- Reset mid-operation: a pending rsp_valid is cleared immediately; no write occurs while reset = 1.
- Throughput:
  - One transaction per cycle.
  - With all R requesting continuously, each is granted exactly once every R cycles.

Optional Feature:
REGFILE_ARB_CLEAR_EN.
- Defined:
  - Adds ports clear_start (input, 1) and clear_busy (output, 1), plus a 2-state FSM IDLE/CLEAR with an AW-bit clear counter.
  - A clear_start pulse in IDLE: -> CLEAR with counter = 0. Clear wins over any same-cycle request; that request is not accepted.
  - In CLEAR: rf_write_enable = 1, rf_write_addr = counter, rf_write_data = 0, req_ready = 0, clear_busy = 1; counter increments each cycle.
  - After address M-1 is written: -> IDLE. The sequence takes exactly M cycles.
  - clear_start is ignored while in CLEAR.
  - rr_ptr is unchanged by a clear.
  - Reset -> IDLE, counter = 0.
- Not defined: the ports, FSM and counter are absent; behaviour is as above.

Decomposition:
- Shared package regfile_pkg: default N/M/R constants and the AW derivation function.
- One sub-module, rr_arbiter #(R): takes req, ptr and grant enable; produces the one-hot grant and the next pointer. Reusable for other shared resources.
- Datapath muxing of addr/data stays in the top module.

Test Plan:
- Reset asserted, all req_valid = 1 -> req_ready = 0, rf_write_enable = 0, rsp_valid = 0; after release, first grant goes to requester 0.
- Req0 writes addr 2 = 0xF0, next cycle req1 reads addr 2 -> rsp_valid = 2'b10 one cycle later, rsp_rdata = 0xF0.
- R = 3, all three hold reads of addrs 0/1/3 for 9 cycles -> grants cycle 0,1,2,0,1,2,...; each rsp_valid pulses 3 times with the correct data.
- Req1 and req0 valid simultaneously with rr_ptr = 1 -> req1 granted first, then req0; rr_ptr ends at 1.
- Assert reset in the cycle after a read grant -> rsp_valid drops immediately, rsp_rdata = 0, registers unchanged.
- (REGFILE_ARB_CLEAR_EN) Fill all 4 regs with 0xAA, pulse clear_start with req0 valid -> clear_busy high 4 cycles, req_ready = 0 throughout; then req0 is granted and reads return 0x00.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file port arbiter slice.
package regfile_pkg;

  localparam int DEF_R = 2;
  localparam int DEF_N = 8;
  localparam int DEF_M = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int addr_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant starting the search at ptr_i, plus the pointer
// value that follows the winner (wrapping at R-1 even when R is not a power of two).
module rr_arbiter #(
  parameter  int R  = 2,
  localparam int PW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [R-1:0]  grant_o,
  output logic [PW-1:0] winner_o,
  output logic          valid_o,
  output logic [PW-1:0] next_ptr_o
);

  logic any_req_s;

  // Scan from the farthest slot back to ptr_i so the nearest requester is assigned last and wins.
  always_comb begin
    int idx;
    winner_o  = ptr_i;
    any_req_s = 1'b0;
    for (int k = R - 1; k >= 0; k--) begin
      idx       = int'(ptr_i) + k;
      idx       = (idx >= R) ? (idx - R) : idx;
      winner_o  = req_i[idx] ? PW'(idx) : winner_o;
      any_req_s = any_req_s | req_i[idx];
    end
    valid_o    = any_req_s & en_i;
    grant_o    = valid_o ? (R'(1) << winner_o) : '0;
    next_ptr_o = (int'(winner_o) == R - 1) ? '0 : winner_o + PW'(1);
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin sharing of one RegisterFile write port and one read port among R requesters.
// Optional macro REGFILE_ARB_CLEAR_EN adds clear_start/clear_busy and a sequencer zeroing every register.
module regfile_port_arbiter
  import regfile_pkg::*;
#(
  parameter  int R  = DEF_R,
  parameter  int N  = DEF_N,
  parameter  int M  = DEF_M,
  localparam int AW = addr_width(M),
  localparam int PW = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [R-1:0]    req_valid,
  input  logic [R-1:0]    req_we,
  input  logic [R*AW-1:0] req_addr,
  input  logic [R*N-1:0]  req_wdata,
  output logic [R-1:0]    req_ready,
  output logic [R-1:0]    rsp_valid,
  output logic [N-1:0]    rsp_rdata,
  output logic            rf_write_enable,
  output logic [AW-1:0]   rf_write_addr,
  output logic [N-1:0]    rf_write_data,
  output logic [AW-1:0]   rf_read_addr,
  input  logic [N-1:0]    rf_read_data
`ifdef REGFILE_ARB_CLEAR_EN
  ,
  input  logic            clear_start,
  output logic            clear_busy
`endif
);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [R-1:0]  rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;

  logic [R-1:0]  grant_s;
  logic [PW-1:0] winner_s;
  logic [PW-1:0] next_ptr_s;
  logic          grant_valid_s;
  logic          grant_en_s;
  logic [AW-1:0] win_addr_s;
  logic [N-1:0]  win_wdata_s;
  logic          win_we_s;
  logic          wr_grant_s;
  logic          rd_grant_s;
  logic          clear_active_s;
  logic [AW-1:0] clear_addr_s;

`ifdef REGFILE_ARB_CLEAR_EN
  clr_state_e    clr_state_q;
  logic [AW-1:0] clr_cnt_q;
  logic          clr_busy_q;

  // Clear sequencer: a start pulse in IDLE walks the counter over every address exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_state_q <= ST_IDLE;
      clr_cnt_q   <= '0;
      clr_busy_q  <= 1'b0;
    end else begin
      case (clr_state_q)
        ST_IDLE: begin
          if (clear_start) begin
            clr_state_q <= ST_CLEAR;
            clr_cnt_q   <= '0;
            clr_busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == AW'(M - 1)) begin
            clr_state_q <= ST_IDLE;
            clr_cnt_q   <= '0;
            clr_busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        default: begin
          clr_state_q <= ST_IDLE;
          clr_cnt_q   <= '0;
          clr_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clear_busy     = clr_busy_q;
  assign clear_active_s = (clr_state_q == ST_CLEAR);
  assign clear_addr_s   = clr_cnt_q;
  // A start pulse pre-empts any request in the same cycle.
  assign grant_en_s     = ~reset & (clr_state_q == ST_IDLE) & ~clear_start;
`else
  assign clear_active_s = 1'b0;
  assign clear_addr_s   = '0;
  assign grant_en_s     = ~reset;
`endif

  rr_arbiter #(.R(R)) u_rr_arbiter (
    .req_i      (req_valid),
    .ptr_i      (rr_ptr_q),
    .en_i       (grant_en_s),
    .grant_o    (grant_s),
    .winner_o   (winner_s),
    .valid_o    (grant_valid_s),
    .next_ptr_o (next_ptr_s)
  );

  // Select the winning requester's fields and classify the grant.
  always_comb begin
    win_addr_s  = req_addr[int'(winner_s)*AW +: AW];
    win_wdata_s = req_wdata[int'(winner_s)*N +: N];
    win_we_s    = req_we[winner_s];
    wr_grant_s  = grant_valid_s & win_we_s;
    rd_grant_s  = grant_valid_s & ~win_we_s;
  end

  // Write port drive; address and data are zero whenever no write is in flight.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    if (clear_active_s && !reset) begin
      rf_write_enable = 1'b1;
      rf_write_addr   = clear_addr_s;
      rf_write_data   = '0;
    end else if (wr_grant_s) begin
      rf_write_enable = 1'b1;
      rf_write_addr   = win_addr_s;
      rf_write_data   = win_wdata_s;
    end else begin
      rf_write_enable = 1'b0;
    end
  end

  assign req_ready    = grant_s;
  assign rf_read_addr = rd_grant_s ? win_addr_s : rd_addr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;

  // Next-state for pointer, read response and the held read address.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rd_addr_d   = rd_addr_q;
    if (grant_valid_s) begin
      rr_ptr_d = next_ptr_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (rd_grant_s) begin
      rsp_valid_d = grant_s;
      rsp_rdata_d = rf_read_data;
      rd_addr_d   = win_addr_s;
    end else begin
      rsp_valid_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rd_addr_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed self-checking bench for regfile_port_arbiter (R=3, N=8, M=4) with a behavioural RegisterFile.
module tb_regfile_port_arbiter;

  localparam int R  = 3;
  localparam int N  = 8;
  localparam int M  = 4;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [R-1:0]    req_valid;
  logic [R-1:0]    req_we;
  logic [R*AW-1:0] req_addr;
  logic [R*N-1:0]  req_wdata;
  logic [R-1:0]    req_ready;
  logic [R-1:0]    rsp_valid;
  logic [N-1:0]    rsp_rdata;
  logic            rf_write_enable;
  logic [AW-1:0]   rf_write_addr;
  logic [N-1:0]    rf_write_data;
  logic [AW-1:0]   rf_read_addr;
  logic [N-1:0]    rf_read_data;
`ifdef REGFILE_ARB_CLEAR_EN
  logic            clear_start;
  logic            clear_busy;
`endif

  logic [N-1:0] rf_mem [M];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
  end
  assign rf_read_data = rf_mem[rf_read_addr];

  regfile_port_arbiter #(.R(R), .N(N), .M(M)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rf_read_addr    (rf_read_addr),
    .rf_read_data    (rf_read_data)
`ifdef REGFILE_ARB_CLEAR_EN
    ,
    .clear_start     (clear_start),
    .clear_busy      (clear_busy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [N-1:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*N +: N]  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0] rr_data [R];
    int           rr_cnt  [R];
    int           w;

    rr_data[0] = 8'h11;
    rr_data[1] = 8'h22;
    rr_data[2] = 8'h33;
    for (int j = 0; j < R; j++) rr_cnt[j] = 0;

    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef REGFILE_ARB_CLEAR_EN
    clear_start = 1'b0;
`endif
    set_req(0, 1'b1, 1'b1, 2'd0, 8'h11);
    set_req(1, 1'b1, 1'b1, 2'd1, 8'h22);
    set_req(2, 1'b1, 1'b1, 2'd3, 8'h33);
    #2;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_we", 32'(rf_write_enable), 32'h0);
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    tick();
    check("rst_ready_hold", 32'(req_ready), 32'h0);
    check("rst_we_hold", 32'(rf_write_enable), 32'h0);

    // All three write after release: grants 0, 1, 2 in turn.
    reset = 1'b0;
    #1;
    check("first_grant", 32'(req_ready), 32'h1);
    check("wr_en_a", 32'(rf_write_enable), 32'h1);
    check("wr_addr_a", 32'(rf_write_addr), 32'h0);
    check("wr_data_a", 32'(rf_write_data), 32'h11);
    tick();
    req_valid[0] = 1'b0;
    #1;
    check("grant_b", 32'(req_ready), 32'h2);
    check("wr_addr_b", 32'(rf_write_addr), 32'h1);
    check("wr_data_b", 32'(rf_write_data), 32'h22);
    tick();
    req_valid[1] = 1'b0;
    #1;
    check("grant_c", 32'(req_ready), 32'h4);
    check("wr_addr_c", 32'(rf_write_addr), 32'h3);
    check("wr_data_c", 32'(rf_write_data), 32'h33);
    tick();
    req_valid = '0;
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    check("idle_we", 32'(rf_write_enable), 32'h0);
    check("idle_waddr", 32'(rf_write_addr), 32'h0);
    check("idle_wdata", 32'(rf_write_data), 32'h0);
    check("no_wr_rsp", 32'(rsp_valid), 32'h0);

    // Write then read-after-write on the next cycle (pointer is 0 here).
    set_req(0, 1'b1, 1'b1, 2'd2, 8'hF0);
    #1;
    check("raw_wr_grant", 32'(req_ready), 32'h1);
    check("raw_wr_addr", 32'(rf_write_addr), 32'h2);
    check("raw_wr_data", 32'(rf_write_data), 32'hF0);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b0, 2'd2, 8'h00);
    #1;
    check("raw_rd_grant", 32'(req_ready), 32'h2);
    check("raw_rd_we", 32'(rf_write_enable), 32'h0);
    check("raw_rd_addr", 32'(rf_read_addr), 32'h2);
    tick();
    req_valid = '0;
    check("raw_rsp_valid", 32'(rsp_valid), 32'h2);
    check("raw_rsp_rdata", 32'(rsp_rdata), 32'hF0);
    #1;
    check("raddr_hold", 32'(rf_read_addr), 32'h2);
    tick();
    check("rsp_pulse_end", 32'(rsp_valid), 32'h0);
    check("rdata_hold", 32'(rsp_rdata), 32'hF0);

    // All three hold reads for 9 cycles; pointer starts at 2.
    set_req(0, 1'b1, 1'b0, 2'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 2'd1, 8'h00);
    set_req(2, 1'b1, 1'b0, 2'd3, 8'h00);
    for (int c = 0; c < 9; c++) begin
      w = (2 + c) % 3;
      #1;
      check("rr_ready", 32'(req_ready), 32'h1 << w);
      tick();
      check("rr_rsp_valid", 32'(rsp_valid), 32'h1 << w);
      check("rr_rsp_rdata", 32'(rsp_rdata), 32'(rr_data[w]));
      for (int j = 0; j < R; j++) rr_cnt[j] += int'(rsp_valid[j]);
    end
    for (int j = 0; j < R; j++) check("rr_pulse_count", 32'(rr_cnt[j]), 32'd3);

    // Move the pointer to 1, then req0 and req1 together.
    req_valid = 3'b001;
    #1;
    check("ptr_setup", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b011;
    #1;
    check("ptr1_r1_first", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b001;
    #1;
    check("then_r0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b011;
    #1;
    check("ptr_back_at_1", 32'(req_ready), 32'h2);
    tick();
    check("pre_rst_rsp", 32'(rsp_valid), 32'h2);
    check("pre_rst_rdata", 32'(rsp_rdata), 32'h22);

    // Reset asserted the cycle after a read grant, with writes pending.
    reset = 1'b1;
    set_req(0, 1'b1, 1'b1, 2'd2, 8'h55);
    set_req(1, 1'b1, 1'b1, 2'd0, 8'h66);
    set_req(2, 1'b1, 1'b1, 2'd1, 8'h77);
    #1;
    check("rst_mid_rsp", 32'(rsp_valid), 32'h0);
    check("rst_mid_rdata", 32'(rsp_rdata), 32'h0);
    check("rst_mid_ready", 32'(req_ready), 32'h0);
    check("rst_mid_we", 32'(rf_write_enable), 32'h0);
    tick();
    tick();
    check("rst_mid_mem0", 32'(rf_mem[0]), 32'h11);
    check("rst_mid_mem2", 32'(rf_mem[2]), 32'hF0);
    reset = 1'b0;
    req_valid = '0;
    set_req(1, 1'b1, 1'b0, 2'd2, 8'h00);
    set_req(2, 1'b1, 1'b0, 2'd3, 8'h00);
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("post_rst_rsp", 32'(rsp_valid), 32'h2);
    check("post_rst_rdata", 32'(rsp_rdata), 32'hF0);

`ifdef REGFILE_ARB_CLEAR_EN
    for (int a = 0; a < M; a++) begin
      set_req(0, 1'b1, 1'b1, AW'(a), 8'hAA);
      tick();
    end
    check("fill_mem3", 32'(rf_mem[3]), 32'hAA);
    set_req(0, 1'b1, 1'b0, 2'd1, 8'h00);
    clear_start = 1'b1;
    #1;
    check("clr_start_ready", 32'(req_ready), 32'h0);
    check("clr_start_we", 32'(rf_write_enable), 32'h0);
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < M; k++) begin
      check("clr_busy", 32'(clear_busy), 32'h1);
      check("clr_ready", 32'(req_ready), 32'h0);
      check("clr_we", 32'(rf_write_enable), 32'h1);
      check("clr_waddr", 32'(rf_write_addr), 32'(k));
      check("clr_wdata", 32'(rf_write_data), 32'h0);
      tick();
    end
    check("clr_done_busy", 32'(clear_busy), 32'h0);
    check("clr_done_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("clr_rd_valid", 32'(rsp_valid), 32'h1);
    check("clr_rd_data", 32'(rsp_rdata), 32'h0);
    check("clr_mem3", 32'(rf_mem[3]), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
